aes_inv_key_sched: RTL

Sequential decryption key scheduler for AES-128. It takes a 128-bit cipher key, expands it forward to the round-10 key, then emits round keys in reverse order (10 down to 0) over a valid/ready stream. It sits directly upstream of the AddRoundKey stage that feeds `inv_mixcolumns` in the decryption datapath. No 11-entry key store is used; each earlier key is recomputed by the inverse expansion step.

---
 rtl/aes_pkg.sv | 49 ++++
 rtl/aes_subword.sv | 15 +
 rtl/aes_inv_key_sched.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES helpers: S-box, rcon stepping and key-scheduler state type.
// Pure combinational functions; no latency, no flow control.
package aes_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXPAND,
        ST_EMIT
    } keysched_state_t;

    localparam logic [7:0] RCON_FIRST = 8'h01;
    localparam logic [7:0] RCON_LAST  = 8'h36;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Walks rcon backwards; 0x1b is the only value whose predecessor wrapped.
    function automatic logic [7:0] inv_xtime(input logic [7:0] b);
        return (b == 8'h1b) ? 8'h80 : {1'b0, b[7:1]};
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // GF(2^8) inverse as a^254 (maps 0 to 0), followed by the AES affine map.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = a;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

endpackage

// File: rtl/aes_subword.sv
// Four parallel S-box lookups on a 32-bit word, no rotation.
// Combinational, zero latency, no flow control.
module aes_subword
    import aes_pkg::*;
(
    input  logic [31:0] word_in,
    output logic [31:0] word_out
);

    assign word_out[31:24] = sbox(word_in[31:24]);
    assign word_out[23:16] = sbox(word_in[23:16]);
    assign word_out[15:8]  = sbox(word_in[15:8]);
    assign word_out[7:0]   = sbox(word_in[7:0]);

endmodule

// File: rtl/aes_inv_key_sched.sv
// AES-128 decryption key scheduler: first round key 11 cycles after key_load, then rounds 10..0 one per
// rk_valid/rk_ready handshake (rk_ready low holds the key). Optional round-0 self-check: AES_KEYSCHED_SELFCHECK_EN.
module aes_inv_key_sched
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         key_load,
    input  logic [127:0] key_in,
    output logic         busy,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [127:0] rk,
    output logic [3:0]   rk_round,
    output logic         rk_last,
    output logic         err
);

    keysched_state_t state_q, state_d;
    logic [127:0]    key_q, key_d;
    logic [7:0]      rcon_q, rcon_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            busy_q, busy_d;
    logic            rk_valid_q, rk_valid_d;

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] sub_in, sub_out, t0;
    logic [127:0] key_fwd, key_inv;
    logic         rk_hs;

    assign {w0, w1, w2, w3} = key_q;

    // One S-box word serves both directions: w3 going forward, w3^w2 (= previous w3) going back.
    assign sub_in = (state_q == ST_EXPAND) ? w3 : (w3 ^ w2);

    aes_subword u_subword (
        .word_in  (sub_in),
        .word_out (sub_out)
    );

    assign t0      = w0 ^ {sub_out[23:0], sub_out[31:24]} ^ {rcon_q, 24'h0};
    assign key_fwd = {t0, w1 ^ t0, w2 ^ w1 ^ t0, w3 ^ w2 ^ w1 ^ t0};
    assign key_inv = {t0, w1 ^ w0, w2 ^ w1, w3 ^ w2};
    assign rk_hs   = rk_valid_q && rk_ready;

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        rcon_d  = rcon_q;
        cnt_d   = cnt_q;
        if (key_load) begin
            key_d   = key_in;
            rcon_d  = RCON_FIRST;
            cnt_d   = 4'd0;
            state_d = ST_EXPAND;
        end else begin
            case (state_q)
                ST_EXPAND: begin
                    key_d  = key_fwd;
                    cnt_d  = cnt_q + 4'd1;
                    rcon_d = xtime(rcon_q);
                    if (cnt_q == 4'd9) begin
                        rcon_d  = RCON_LAST;
                        state_d = ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    if (rk_hs) begin
                        if (cnt_q == 4'd0) begin
                            state_d = ST_IDLE;
                        end else begin
                            key_d  = key_inv;
                            cnt_d  = cnt_q - 4'd1;
                            rcon_d = inv_xtime(rcon_q);
                        end
                    end
                end
                default: ;
            endcase
        end
        busy_d     = (state_d != ST_IDLE);
        rk_valid_d = (state_d == ST_EMIT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            key_q      <= '0;
            rcon_q     <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            rk_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            key_q      <= key_d;
            rcon_q     <= rcon_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            rk_valid_q <= rk_valid_d;
        end
    end

    assign busy     = busy_q;
    assign rk_valid = rk_valid_q;
    assign rk       = key_q;
    assign rk_round = cnt_q;
    assign rk_last  = rk_valid_q && (cnt_q == 4'd0);

`ifdef AES_KEYSCHED_SELFCHECK_EN
    // Walking the schedule back to round 0 must reproduce the loaded key exactly.
    logic [127:0] shadow_q, shadow_d;
    logic         err_q, err_d;

    always_comb begin
        shadow_d = shadow_q;
        err_d    = err_q;
        if (key_load) begin
            shadow_d = key_in;
            err_d    = 1'b0;
        end else if ((state_q == ST_EMIT) && rk_hs && (cnt_q == 4'd0) && (key_q != shadow_q)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= '0;
            err_q    <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            err_q    <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule
